wdt_multi: RTL and testbench

WDT_MULTI -- requirements
Module: wdt_multi

---
 rtl/wdt_pkg.sv | 39 +++
 rtl/wdt_channel.sv | 122 ++++++++++++
 rtl/wdt_multi.sv | 130 +++++++++++++
 tb/tb_wdt_multi.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wdt_pkg.sv
// -----------------------------------------------------------------------------
// wdt_pkg
//   Shared constants and helpers for the multi-channel watchdog.
//   - DEF_* : default parameter values used by wdt_multi / wdt_channel
//   - clog2 : ceiling log2, used to size counters from parameters
//   - ch_act_e : the single action a channel takes on a given clock edge
// -----------------------------------------------------------------------------
package wdt_pkg;

    localparam int unsigned DEF_N_CH        = 4;
    localparam int unsigned DEF_CLK_FREQ    = 125000000;
    localparam int unsigned DEF_TIMEOUT_SEC = 5;
    localparam int unsigned DEF_WARN_SEC    = 4;
    localparam int unsigned DEF_WIN_MIN_SEC = 1;
    localparam int unsigned DEF_ESC_LIMIT   = 3;
    localparam int unsigned ESC_W           = 4;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(6) = 3.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

    // Highest-priority event seen by a channel in one cycle.
    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_OFF,
        ACT_CLEAR,
        ACT_KICK,
        ACT_EARLY,
        ACT_EXPIRE,
        ACT_TICK
    } ch_act_e;

endpackage

// File: rtl/wdt_channel.sv
// -----------------------------------------------------------------------------
// wdt_channel
//   One watchdog channel: seconds counter, sticky trigger / early-kick fault,
//   warning flag and seconds-remaining readout.
//
//   clk, rstn        : clock, asynchronous active-low reset
//   tick             : one-cycle pulse, one per second (shared prescaler)
//   enable           : channel enable; low holds the channel cleared
//   heartbeat        : kick pulse
//   clear            : fault clear
//   window_en        : kicks before WIN_MIN_SEC count as a fault
//   triggered        : sticky timeout / early fault
//   warning          : triggered, or counter at/above WARN_SEC
//   early_fault      : sticky, a kick landed inside the closed window
//   time_remaining   : seconds left, 0 once triggered
// -----------------------------------------------------------------------------
module wdt_channel
    import wdt_pkg::*;
#(
    parameter int unsigned TIMEOUT_SEC = DEF_TIMEOUT_SEC,
    parameter int unsigned WARN_SEC    = DEF_WARN_SEC,
    parameter int unsigned WIN_MIN_SEC = DEF_WIN_MIN_SEC
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tick,
    input  logic       enable,
    input  logic       heartbeat,
    input  logic       clear,
    input  logic       window_en,
    output logic       triggered,
    output logic       warning,
    output logic       early_fault,
    output logic [7:0] time_remaining
);

    localparam int unsigned    CW      = clog2(TIMEOUT_SEC + 1);
    localparam logic [CW-1:0]  C_MAX   = CW'(TIMEOUT_SEC);
    localparam logic [CW-1:0]  C_WARN  = CW'(WARN_SEC);
    localparam logic [CW-1:0]  C_WIN   = CW'(WIN_MIN_SEC);
    localparam logic [7:0]     TO8     = 8'(TIMEOUT_SEC);

    logic [CW-1:0] r_cnt;
    logic          r_trig;
    logic          r_warn;
    logic          r_early;

    ch_act_e       w_act;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_trig_nxt;
    logic          w_warn_nxt;
    logic          w_early_nxt;

    // Priority decode: exactly one action per edge.
    always_comb begin
        w_act = ACT_HOLD;
        if (!enable) begin
            w_act = ACT_OFF;
        end else if (clear) begin
            w_act = ACT_CLEAR;
        end else if (heartbeat) begin
            w_act = (window_en && (r_cnt < C_WIN)) ? ACT_EARLY : ACT_KICK;
        end else if (r_cnt == C_MAX) begin
            w_act = ACT_EXPIRE;
        end else if (tick) begin
            w_act = ACT_TICK;
        end
    end

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_trig_nxt  = r_trig;
        w_early_nxt = r_early;
        unique case (w_act)
            ACT_OFF, ACT_CLEAR: begin
                w_cnt_nxt   = '0;
                w_trig_nxt  = 1'b0;
                w_early_nxt = 1'b0;
            end
            // A kick restarts the count but never clears a latched trigger.
            ACT_KICK: begin
                w_cnt_nxt = '0;
            end
            ACT_EARLY: begin
                w_cnt_nxt   = '0;
                w_trig_nxt  = 1'b1;
                w_early_nxt = 1'b1;
            end
            ACT_EXPIRE: begin
                w_trig_nxt = 1'b1;
            end
            ACT_TICK: begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
            default: ;
        endcase
        // Warning is registered from the post-edge state so it lines up with
        // the counter value it describes.
        w_warn_nxt = w_trig_nxt | (w_cnt_nxt >= C_WARN);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt   <= '0;
            r_trig  <= 1'b0;
            r_warn  <= 1'b0;
            r_early <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_trig  <= w_trig_nxt;
            r_warn  <= w_warn_nxt;
            r_early <= w_early_nxt;
        end
    end

    assign triggered      = r_trig;
    assign warning        = r_warn;
    assign early_fault    = r_early;
    // TIMEOUT_SEC <= 255, so the difference always fits in 8 bits.
    assign time_remaining = r_trig ? '0 : (TO8 - 8'(r_cnt));

endmodule

// File: rtl/wdt_multi.sv
// -----------------------------------------------------------------------------
// wdt_multi
//   N_CH independent watchdog channels sharing a one-second prescaler, with a
//   common escalation counter that requests a system reset after ESC_LIMIT
//   trigger events.
//
//   clk, rstn       : clock, asynchronous active-low reset
//   enable          : [N_CH] per-channel enable
//   heartbeat       : [N_CH] per-channel kick pulse
//   clear           : [N_CH] per-channel fault clear
//   window_en       : [N_CH] per-channel window mode
//   esc_ack         : clears escalation count and sys_reset_req
//   triggered       : [N_CH] sticky timeout / early fault
//   warning         : [N_CH] pre-timeout warning
//   early_fault     : [N_CH] sticky early-kick fault
//   time_remaining  : [8*N_CH] seconds left, channel i at [8i+7:8i]
//   any_triggered   : OR of triggered
//   sys_reset_req   : sticky escalation output
// -----------------------------------------------------------------------------
module wdt_multi
    import wdt_pkg::*;
#(
    parameter int unsigned N_CH        = DEF_N_CH,
    parameter int unsigned CLK_FREQ    = DEF_CLK_FREQ,
    parameter int unsigned TIMEOUT_SEC = DEF_TIMEOUT_SEC,
    parameter int unsigned WARN_SEC    = DEF_WARN_SEC,
    parameter int unsigned WIN_MIN_SEC = DEF_WIN_MIN_SEC,
    parameter int unsigned ESC_LIMIT   = DEF_ESC_LIMIT
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [N_CH-1:0]     enable,
    input  logic [N_CH-1:0]     heartbeat,
    input  logic [N_CH-1:0]     clear,
    input  logic [N_CH-1:0]     window_en,
    input  logic                esc_ack,
    output logic [N_CH-1:0]     triggered,
    output logic [N_CH-1:0]     warning,
    output logic [N_CH-1:0]     early_fault,
    output logic [8*N_CH-1:0]   time_remaining,
    output logic                any_triggered,
    output logic                sys_reset_req
);

    // CLK_FREQ = 1 keeps a 1-bit prescaler pinned at 0, so every cycle ticks.
    localparam int unsigned    PW        = (CLK_FREQ > 1) ? clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_FREQ - 1);
    localparam logic [ESC_W-1:0] ESC_MAX = ESC_W'(ESC_LIMIT);

    logic [PW-1:0]    r_presc;
    logic             w_tick;

    logic [N_CH-1:0]  r_trig_prev;
    logic             w_event;
    logic [ESC_W-1:0] r_esc;
    logic [ESC_W-1:0] w_esc_nxt;
    logic             r_sys;
    logic             w_sys_nxt;

    // ---------------- shared prescaler ----------------
    assign w_tick = (r_presc == PRESC_MAX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // ---------------- channels ----------------
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        wdt_channel #(
            .TIMEOUT_SEC (TIMEOUT_SEC),
            .WARN_SEC    (WARN_SEC),
            .WIN_MIN_SEC (WIN_MIN_SEC)
        ) u_ch (
            .clk            (clk),
            .rstn           (rstn),
            .tick           (w_tick),
            .enable         (enable[g]),
            .heartbeat      (heartbeat[g]),
            .clear          (clear[g]),
            .window_en      (window_en[g]),
            .triggered      (triggered[g]),
            .warning        (warning[g]),
            .early_fault    (early_fault[g]),
            .time_remaining (time_remaining[8*g +: 8])
        );
    end

    assign any_triggered = |triggered;

    // ---------------- escalation ----------------
    // Rising edges on several channels in the same cycle collapse into one event.
    assign w_event = |(triggered & ~r_trig_prev);

    always_comb begin
        w_esc_nxt = r_esc;
        w_sys_nxt = r_sys;
        if (esc_ack) begin
            w_esc_nxt = '0;
            w_sys_nxt = 1'b0;
        end else begin
            if (w_event && (r_esc != ESC_MAX)) begin
                w_esc_nxt = r_esc + 1'b1;
            end
            if (w_esc_nxt == ESC_MAX) begin
                w_sys_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_trig_prev <= '0;
            r_esc       <= '0;
            r_sys       <= 1'b0;
        end else begin
            r_trig_prev <= triggered;
            r_esc       <= w_esc_nxt;
            r_sys       <= w_sys_nxt;
        end
    end

    assign sys_reset_req = r_sys;

endmodule

// File: tb/tb_wdt_multi.sv
// -----------------------------------------------------------------------------
// tb_wdt_multi
//   Self-checking bench for wdt_multi with N_CH=2, CLK_FREQ=4, TIMEOUT_SEC=5,
//   WARN_SEC=4, WIN_MIN_SEC=1, ESC_LIMIT=2. Inputs change on the falling edge;
//   outputs are checked on the falling edge after each rising edge.
// -----------------------------------------------------------------------------
module tb_wdt_multi;

    localparam int NCH = 2;
    localparam int CF  = 4;
    localparam int TO  = 5;
    localparam int WR  = 4;
    localparam int WM  = 1;
    localparam int EL  = 2;

    logic             clk;
    logic             rstn;
    logic [NCH-1:0]   enable;
    logic [NCH-1:0]   heartbeat;
    logic [NCH-1:0]   clear;
    logic [NCH-1:0]   window_en;
    logic             esc_ack;
    logic [NCH-1:0]   triggered;
    logic [NCH-1:0]   warning;
    logic [NCH-1:0]   early_fault;
    logic [8*NCH-1:0] time_remaining;
    logic             any_triggered;
    logic             sys_reset_req;

    int n_checks = 0;
    int n_fail   = 0;

    wdt_multi #(
        .N_CH        (NCH),
        .CLK_FREQ    (CF),
        .TIMEOUT_SEC (TO),
        .WARN_SEC    (WR),
        .WIN_MIN_SEC (WM),
        .ESC_LIMIT   (EL)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .enable         (enable),
        .heartbeat      (heartbeat),
        .clear          (clear),
        .window_en      (window_en),
        .esc_ack        (esc_ack),
        .triggered      (triggered),
        .warning        (warning),
        .early_fault    (early_fault),
        .time_remaining (time_remaining),
        .any_triggered  (any_triggered),
        .sys_reset_req  (sys_reset_req)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    // ---------------- reference model (seconds / flags as plain ints) -------
    int m_presc;
    int m_cnt       [NCH];
    bit m_trig      [NCH];
    bit m_early     [NCH];
    bit m_trig_prev [NCH];
    int m_esc;
    bit m_sys;

    function automatic void m_reset();
        m_presc = 0;
        m_esc   = 0;
        m_sys   = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c]       = 0;
            m_trig[c]      = 1'b0;
            m_early[c]     = 1'b0;
            m_trig_prev[c] = 1'b0;
        end
    endfunction

    function automatic void m_step();
        bit tick;
        bit ev;
        tick = (m_presc == CF - 1);
        m_presc = (m_presc + 1) % CF;
        ev = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (m_trig[c] && !m_trig_prev[c]) ev = 1'b1;
            m_trig_prev[c] = m_trig[c];
        end
        if (esc_ack) begin
            m_esc = 0;
            m_sys = 1'b0;
        end else if (ev) begin
            if (m_esc < EL) m_esc++;
            if (m_esc >= EL) m_sys = 1'b1;
        end
        for (int c = 0; c < NCH; c++) begin
            if (!enable[c] || clear[c]) begin
                m_cnt[c] = 0; m_trig[c] = 1'b0; m_early[c] = 1'b0;
            end else if (heartbeat[c]) begin
                if (window_en[c] && m_cnt[c] < WM) begin
                    m_trig[c] = 1'b1; m_early[c] = 1'b1;
                end
                m_cnt[c] = 0;
            end else if (m_cnt[c] == TO) begin
                m_trig[c] = 1'b1;
            end else if (tick) begin
                m_cnt[c]++;
            end
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [NCH-1:0]   et, ew, ee;
        logic [8*NCH-1:0] etr;
        for (int c = 0; c < NCH; c++) begin
            et[c] = m_trig[c];
            ee[c] = m_early[c];
            ew[c] = m_trig[c] || (m_cnt[c] >= WR);
            etr[8*c +: 8] = m_trig[c] ? 8'd0 : 8'(TO - m_cnt[c]);
        end
        check({tag, ".trig"},  32'(triggered),      32'(et));
        check({tag, ".warn"},  32'(warning),        32'(ew));
        check({tag, ".early"}, 32'(early_fault),    32'(ee));
        check({tag, ".trem"},  32'(time_remaining), 32'(etr));
        check({tag, ".any"},   32'(any_triggered),  32'(|et));
        check({tag, ".sys"},   32'(sys_reset_req),  32'(m_sys));
    endtask

    // One rising edge; the model advances with the same pre-edge inputs.
    task automatic cycle();
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstn = 1'b0;
        enable = '0; heartbeat = '0; clear = '0; window_en = '0; esc_ack = 1'b0;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic wait_trig(input logic [NCH-1:0] mask, input string tag);
        int k;
        k = 0;
        while (((triggered & mask) != mask) && (k < 60)) begin
            cycle();
            k++;
        end
        check({tag, ".reached"}, 32'(triggered & mask), 32'(mask));
    endtask

    // ---------------- directed vector table (channel 1, window mode) -------
    typedef struct {
        logic       en1, hb1, clr1, ack;
        logic       trig1, early1, warn1;
        logic [7:0] tr1;
    } vec_t;

    function automatic vec_t mkv(input logic en1, input logic hb1, input logic clr1,
                                 input logic ack, input logic trig1, input logic early1,
                                 input logic warn1, input logic [7:0] tr1);
        vec_t v;
        v.en1 = en1; v.hb1 = hb1; v.clr1 = clr1; v.ack = ack;
        v.trig1 = trig1; v.early1 = early1; v.warn1 = warn1; v.tr1 = tr1;
        return v;
    endfunction

    vec_t tbl [10];

    initial begin
        string tag;
        rstn = 1'b0;
        enable = '0; heartbeat = '0; clear = '0; window_en = '0; esc_ack = 1'b0;
        m_reset();

        //             en hb clr ack | trig early warn trem   (after edge n)
        tbl[0] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5); // 1
        tbl[1] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0); // 2 kick at 0 -> early
        tbl[2] = mkv(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0); // 3 sticky
        tbl[3] = mkv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5); // 4 clear beats tick
        tbl[4] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5); // 5
        tbl[5] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5); // 6
        tbl[6] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5); // 7
        tbl[7] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4); // 8 tick
        tbl[8] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5); // 9 legal kick at 1
        tbl[9] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5); // 10 disabled

        // ---- reset state ----
        @(negedge clk);
        @(negedge clk);
        check("rst.trig",  32'(triggered),      32'd0);
        check("rst.warn",  32'(warning),        32'd0);
        check("rst.early", 32'(early_fault),    32'd0);
        check("rst.trem",  32'(time_remaining), 32'h0505);
        check("rst.any",   32'(any_triggered),  32'd0);
        check("rst.sys",   32'(sys_reset_req),  32'd0);
        rstn = 1'b1;

        // ---- table ----
        for (int i = 0; i < 10; i++) begin
            enable    = {tbl[i].en1, 1'b0};
            heartbeat = {tbl[i].hb1, 1'b0};
            clear     = {tbl[i].clr1, 1'b0};
            window_en = 2'b10;
            esc_ack   = tbl[i].ack;
            cycle();
            tag = $sformatf("tbl%0d", i);
            check({tag, ".trig"},  32'(triggered),      32'({tbl[i].trig1, 1'b0}));
            check({tag, ".early"}, 32'(early_fault),    32'({tbl[i].early1, 1'b0}));
            check({tag, ".warn"},  32'(warning),        32'({tbl[i].warn1, 1'b0}));
            check({tag, ".trem"},  32'(time_remaining), 32'({tbl[i].tr1, 8'd5}));
            check({tag, ".any"},   32'(any_triggered),  32'(tbl[i].trig1));
            check_model(tag);
        end

        // ---- free-running timeout on ch0 ----
        apply_reset();
        enable = 2'b01;
        for (int k = 1; k <= 24; k++) begin
            cycle();
            tag = $sformatf("to.e%0d", k);
            check({tag, ".trem0"}, 32'(time_remaining[7:0]), (k >= 20) ? 32'd0 : 32'(5 - k / 4));
            check({tag, ".warn0"}, 32'(warning[0]),   32'(k >= 16));
            check({tag, ".trig0"}, 32'(triggered[0]), 32'(k >= 21));
        end

        // ---- regular kicks keep ch0 quiet ----
        apply_reset();
        enable = 2'b01;
        for (int k = 1; k <= 60; k++) begin
            heartbeat = {1'b0, (k % 12 == 0)};
            cycle();
            tag = $sformatf("kick.e%0d", k);
            check({tag, ".warn0"}, 32'(warning[0]),   32'd0);
            check({tag, ".trig0"}, 32'(triggered[0]), 32'd0);
            if (k % 12 == 0) check({tag, ".trem0"}, 32'(time_remaining[7:0]), 32'd5);
        end
        heartbeat = '0;

        // ---- escalation ----
        apply_reset();
        enable = 2'b11;
        wait_trig(2'b11, "esc1");
        cycle();
        check("esc1.sys", 32'(sys_reset_req), 32'd0);
        clear = 2'b11; cycle(); clear = '0;
        check("esc.cleared", 32'(triggered), 32'd0);
        wait_trig(2'b11, "esc2");
        cycle();
        check("esc2.sys_set", 32'(sys_reset_req), 32'd1);
        esc_ack = 1'b1; cycle(); esc_ack = 1'b0;
        check("esc.ack_clears", 32'(sys_reset_req), 32'd0);
        clear = 2'b11; cycle(); clear = '0;
        wait_trig(2'b11, "esc3");
        esc_ack = 1'b1; cycle(); esc_ack = 1'b0;          // ack on the event cycle
        check("esc3.sys", 32'(sys_reset_req), 32'd0);
        clear = 2'b11; cycle(); clear = '0;
        wait_trig(2'b11, "esc4");
        cycle();
        check("esc.ack_discards_event", 32'(sys_reset_req), 32'd0);
        clear = 2'b11; cycle(); clear = '0;
        wait_trig(2'b11, "esc5");
        cycle();
        check("esc5.sys_set", 32'(sys_reset_req), 32'd1);
        check_model("esc.end");

        // ---- kick after trigger, then disable ----
        apply_reset();
        enable = 2'b01;
        wait_trig(2'b01, "hbt");
        heartbeat = 2'b01; cycle(); heartbeat = '0;
        check("hbt.trig_kept", 32'(triggered[0]), 32'd1);
        check_model("hbt");
        enable = 2'b00; cycle();
        check("dis.trig0",  32'(triggered[0]),       32'd0);
        check("dis.warn0",  32'(warning[0]),         32'd0);
        check("dis.early0", 32'(early_fault[0]),     32'd0);
        check("dis.trem0",  32'(time_remaining[7:0]), 32'd5);

        // ---- asynchronous reset mid-count ----
        apply_reset();
        enable = 2'b01;
        repeat (12) cycle();
        check("arst.pre_trem0", 32'(time_remaining[7:0]), 32'd2);
        #3 rstn = 1'b0;
        #1;
        check("arst.trig",  32'(triggered),      32'd0);
        check("arst.warn",  32'(warning),        32'd0);
        check("arst.early", 32'(early_fault),    32'd0);
        check("arst.trem",  32'(time_remaining), 32'h0505);
        check("arst.sys",   32'(sys_reset_req),  32'd0);
        m_reset();
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            check($sformatf("arst.e%0d.trem0", k), 32'(time_remaining[7:0]), (k < 4) ? 32'd5 : 32'd4);
        end

        // ---- randomized run against the model ----
        apply_reset();
        enable = 2'b11;
        window_en = 2'($urandom_range(0, 3));
        for (int k = 0; k < 2000; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 63) == 0) enable[c] = ~enable[c];
                if ($urandom_range(0, 39) == 0) window_en[c] = ~window_en[c];
                heartbeat[c] = ($urandom_range(0, 15) == 0);
                clear[c]     = ($urandom_range(0, 99) == 0);
            end
            esc_ack = ($urandom_range(0, 49) == 0);
            cycle();
            check_model($sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
